// File: rtl/gate_pkg.sv
// -----------------------------------------------------------------------------
// gate_pkg
// Shared definitions for the gate-unit arbiter slice:
//   - OP_* : 3-bit opcodes understood by the shared gate unit (7 is illegal)
//   - state_e : arbiter FSM state encoding (2 bits)
// -----------------------------------------------------------------------------
package gate_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/gate_alu.sv
// -----------------------------------------------------------------------------
// gate_alu
// Purely combinational WIDTH-bit bitwise logic unit; the single shared
// resource behind gate_unit_arbiter.
// Ports:
//   op  [2:0]       opcode (OP_AND..OP_NOT, OP_ILL)
//   a   [WIDTH-1:0] operand A
//   b   [WIDTH-1:0] operand B (ignored for OP_NOT)
//   y   [WIDTH-1:0] result (zero for an illegal opcode)
//   err             high for an illegal opcode
// -----------------------------------------------------------------------------
module gate_alu
    import gate_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    always_comb begin
        y   = '0;
        err = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/gate_unit_arbiter.sv
// -----------------------------------------------------------------------------
// gate_unit_arbiter
// Round-robin arbiter sharing one gate_alu between N_REQ requesters. One
// transaction is outstanding at a time: IDLE (arbitrate/accept) -> EXEC
// (evaluate latched operands, register result) -> RESP (hold until taken).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid [N_REQ-1:0]      per-requester request valid
//   req_ready [N_REQ-1:0]      per-requester accept, one-hot or zero
//   req_op    [3*N_REQ-1:0]    opcode of requester i at [3i+2:3i]
//   req_a/b   [WIDTH*N_REQ-1:0] operands of requester i
//   resp_valid/resp_ready      response handshake
//   resp_id   [IDW-1:0]        index of the served requester
//   resp_data [WIDTH-1:0]      result
//   resp_err                   opcode was illegal
// -----------------------------------------------------------------------------
module gate_unit_arbiter
    import gate_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [3*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_a,
    input  logic [WIDTH*N_REQ-1:0] req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IDW-1:0]         resp_id,
    output logic [WIDTH-1:0]       resp_data,
    output logic                   resp_err
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   resp_id_q, resp_id_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_err_q, resp_err_d;

    logic [2:0]       op_arr [N_REQ];
    logic [WIDTH-1:0] a_arr  [N_REQ];
    logic [WIDTH-1:0] b_arr  [N_REQ];

    logic             pick_found;
    logic [IDW-1:0]   pick_idx;
    logic [IDW-1:0]   scan_idx;
    logic [IDW-1:0]   pick_next;

    logic [WIDTH-1:0] alu_y;
    logic             alu_err;

    // Unpack the flattened request buses into per-requester arrays.
    always_comb begin
        for (int unsigned k = 0; k < N_REQ; k++) begin
            op_arr[k] = req_op[3*k +: 3];
            a_arr[k]  = req_a[WIDTH*k +: WIDTH];
            b_arr[k]  = req_b[WIDTH*k +: WIDTH];
        end
    end

    // Round-robin pick: first valid requester scanning upward from rr_ptr,
    // wrapping at N_REQ (N_REQ need not be a power of two).
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = IDW'((32'(rr_ptr_q) + k) % N_REQ);
            if (!pick_found && req_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    assign pick_next = (pick_idx == IDW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && pick_found) begin
            req_ready[pick_idx] = 1'b1;
        end
    end

    gate_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .y   (alu_y),
        .err (alu_err)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        resp_id_d   = resp_id_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                // In IDLE the picked requester is always ready, so a found
                // pick is exactly the request handshake.
                if (pick_found) begin
                    op_d     = op_arr[pick_idx];
                    a_d      = a_arr[pick_idx];
                    b_d      = b_arr[pick_idx];
                    id_d     = pick_idx;
                    rr_ptr_d = pick_next;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                resp_data_d = alu_y;
                resp_err_d  = alu_err;
                resp_id_d   = id_q;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            resp_id_q   <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            resp_id_q   <= resp_id_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign resp_valid = (state_q == ST_RESP);
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gate_unit_arbiter
// Self-checking bench for gate_unit_arbiter (N_REQ=4, WIDTH=8). A transaction
// level reference model (pending table, round-robin pointer, truth-table
// result) predicts req_ready and the response every cycle.
// -----------------------------------------------------------------------------
module tb_gate_unit_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 8;
    localparam int unsigned IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [3*N-1:0] req_op;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic           resp_valid;
    logic           resp_ready;
    logic [IDW-1:0] resp_id;
    logic [W-1:0]   resp_data;
    logic           resp_err;

    always #5 clk = ~clk;

    gate_unit_arbiter #(
        .N_REQ (N),
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Requester-side state (what each client is currently presenting).
    bit         pend [N];
    logic [2:0] p_op [N];
    logic [W-1:0] p_a [N];
    logic [W-1:0] p_b [N];

    // Reference model state.
    bit         m_busy;
    int         m_rr;
    int         m_resp_cyc;
    int         cyc;
    int         e_id;
    logic [W-1:0] e_data;
    bit         e_err;

    // Per-opcode truth table indexed by {a_bit, b_bit}.
    logic [3:0] tt [8];

    typedef struct {
        int         id;
        logic [W-1:0] data;
        bit         err;
        int         cyc;
    } resp_t;

    resp_t got_q [$];
    int    acc_id_q [$];
    int    acc_cyc_q [$];

    function automatic void ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, output logic [W-1:0] y,
                                   output bit err);
        logic [3:0] t;
        y   = '0;
        err = (op == 3'd7);
        if (!err) begin
            t = tt[op];
            for (int i = 0; i < W; i++) y[i] = t[{a[i], b[i]}];
        end
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]      = pend[i];
            req_op[3*i +: 3]  = p_op[i];
            req_a[W*i +: W]   = p_a[i];
            req_b[W*i +: W]   = p_b[i];
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        pend[i] = 1'b1;
        p_op[i] = op;
        p_a[i]  = a;
        p_b[i]  = b;
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    // Entered and left 1 time unit after a rising edge.
    task automatic step(input bit rdy);
        logic [N-1:0] exp_rdy;
        bit           exp_rv;
        int           w;
        int           j;
        resp_t        r;
        resp_ready = rdy;
        drive_inputs();
        #1;
        exp_rdy = '0;
        w = -1;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                j = (m_rr + k) % N;
                if (w < 0 && pend[j]) w = j;
            end
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
        check_eq("req_ready", req_ready, exp_rdy);
        exp_rv = m_busy && (cyc >= m_resp_cyc);
        check_eq("resp_valid", resp_valid, exp_rv);
        if (exp_rv) begin
            check_eq("resp_id", resp_id, e_id);
            check_eq("resp_data", resp_data, e_data);
            check_eq("resp_err", resp_err, e_err);
        end
        for (int k = 0; k < N; k++) begin
            if (req_ready[k] && req_valid[k]) begin
                acc_id_q.push_back(k);
                acc_cyc_q.push_back(cyc + 1);
            end
        end
        if (resp_valid && resp_ready) begin
            r.id   = int'(resp_id);
            r.data = resp_data;
            r.err  = resp_err;
            r.cyc  = cyc + 1;
            got_q.push_back(r);
        end
        @(posedge clk);
        cyc++;
        if (exp_rv && rdy) begin
            m_busy = 1'b0;
        end else if (w >= 0) begin
            m_busy     = 1'b1;
            m_resp_cyc = cyc + 1;
            ref_op(p_op[w], p_a[w], p_b[w], e_data, e_err);
            e_id       = w;
            m_rr       = (w + 1) % N;
            pend[w]    = 1'b0;
        end
        #1;
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_rr   = 0;
    endtask

    logic [W-1:0] sweep_exp [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0111; tt[3] = 4'b0001;
        tt[4] = 4'b0110; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b0000;
        sweep_exp[0] = 8'h05; sweep_exp[1] = 8'hAF; sweep_exp[2] = 8'hFA;
        sweep_exp[3] = 8'h50; sweep_exp[4] = 8'hAA; sweep_exp[5] = 8'h55;
        sweep_exp[6] = 8'h5A;
        cyc = 0;
        model_reset();
        m_resp_cyc = 0;
        e_id = 0; e_data = '0; e_err = 1'b0;

        // Reset held with every requester valid.
        rst_n      = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 3'(i), 8'h11 * (i + 1), 8'h0F);
        drive_inputs();
        @(posedge clk);
        #1;
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_resp_data", resp_data, 0);
        check_eq("rst_resp_err", resp_err, 0);
        check_eq("rst_resp_id", resp_id, 0);
        check_eq("rst_req_ready", req_ready, 4'b0001);
        rst_n = 1'b1;

        // Fairness: everyone keeps requesting; grants 0,1,2,3,0,1 every 3 cycles.
        acc_id_q.delete(); acc_cyc_q.delete();
        for (int s = 0; s < 18; s++) begin
            step(1'b1);
            for (int i = 0; i < N; i++)
                if (!pend[i]) set_req(i, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end
        check_eq("fair_count", acc_id_q.size(), 6);
        if (acc_id_q.size() >= 6) begin
            for (int k = 0; k < 6; k++) check_eq("fair_order", acc_id_q[k], k % 4);
            for (int k = 1; k < 6; k++) check_eq("fair_gap", acc_cyc_q[k] - acc_cyc_q[k-1], 3);
        end
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int s = 0; s < 4; s++) step(1'b1);

        // Single AND request from requester 2.
        acc_id_q.delete(); acc_cyc_q.delete(); got_q.delete();
        set_req(2, 3'd0, 8'hF0, 8'h3C);
        for (int s = 0; s < 4; s++) step(1'b1);
        check_eq("single_resp_count", got_q.size(), 1);
        if (got_q.size() >= 1 && acc_cyc_q.size() >= 1) begin
            check_eq("single_id", got_q[0].id, 2);
            check_eq("single_data", got_q[0].data, 8'h30);
            check_eq("single_err", got_q[0].err, 0);
            check_eq("single_latency", got_q[0].cyc - acc_cyc_q[0], 2);
        end

        // Opcode sweep on requester 1.
        got_q.delete();
        for (int op = 0; op < 7; op++) begin
            set_req(1, 3'(op), 8'hA5, 8'h0F);
            for (int s = 0; s < 3; s++) step(1'b1);
        end
        check_eq("sweep_count", got_q.size(), 7);
        if (got_q.size() >= 7)
            for (int op = 0; op < 7; op++) check_eq("sweep_data", got_q[op].data, sweep_exp[op]);

        // Backpressure on a NAND, with requester 3 (illegal op) waiting behind it.
        acc_id_q.delete(); acc_cyc_q.delete(); got_q.delete();
        set_req(0, 3'd2, 8'hFF, 8'h0F);
        step(1'b1);
        set_req(3, 3'd7, 8'h5A, 8'hC3);
        step(1'b1);
        for (int s = 0; s < 5; s++) step(1'b0);
        for (int s = 0; s < 5; s++) step(1'b1);
        check_eq("bp_resp_count", got_q.size(), 2);
        if (got_q.size() >= 2 && acc_cyc_q.size() >= 2) begin
            check_eq("bp_data", got_q[0].data, 8'hF0);
            check_eq("bp_hs_cycle", got_q[0].cyc - acc_cyc_q[0], 7);
            check_eq("bp_next_accept", acc_cyc_q[1] - got_q[0].cyc, 1);
            check_eq("ill_id", got_q[1].id, 3);
            check_eq("ill_data", got_q[1].data, 0);
            check_eq("ill_err", got_q[1].err, 1);
        end

        // Reset abort during EXEC.
        set_req(1, 3'd4, 8'h3C, 8'hFF);
        step(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_resp_valid", resp_valid, 0);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive_inputs();
        model_reset();
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 1'b1;
        got_q.delete(); acc_id_q.delete(); acc_cyc_q.delete();
        for (int s = 0; s < 5; s++) step(1'b1);
        check_eq("abort_no_resp", got_q.size(), 0);
        set_req(2, 3'd1, 8'h01, 8'h02);
        set_req(1, 3'd0, 8'hFF, 8'h81);
        step(1'b1);
        check_eq("abort_first_grant", (acc_id_q.size() > 0) ? acc_id_q[0] : -1, 1);
        for (int s = 0; s < 6; s++) step(1'b1);

        // Randomized traffic with withdrawals and random backpressure.
        for (int s = 0; s < 3000; s++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(i, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
                end else if ($urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            step($urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
